load_ext_ctrl: RTL and testbench
================================

# load_ext_ctrl

Multi-cycle load controller for the MIPS data path. It accepts a load request (byte, halfword or word; signed or unsigned), issues one word read to data memory and waits for the acknowledge. It then selects the addressed byte or halfword lane, sign- or zero-extends it to 32 bits, and returns the result over a valid/ready response channel. It sits between the execute stage and the data memory port and owns the sign/zero selection for every load.

## Interface
- `ADDR_WIDTH`, default 32: width of the request and memory addresses.
- `MEM_TIMEOUT`, default 255: maximum number of WAIT cycles before the controller aborts with an error. A value of 0 disables the timeout.
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in 1: load request present.
- `req_ready` out 1: high only in IDLE.
- `req_addr` in ADDR_WIDTH: byte address.
- `req_size` in 2: 00 = byte, 01 = half, 10 = word, 11 = reserved (treated as an error).
- `req_sign` in 1: 1 = sign-extend, 0 = zero-extend. Ignored for word loads.
- `mem_rd` out 1: read strobe, held until `mem_ack`.
- `mem_addr` out ADDR_WIDTH: word-aligned address, with bits [1:0] = 0.
- `mem_ack` in 1: read data is valid this cycle.
- `mem_rdata` in 32: read word.
- `rsp_valid` out 1: result present.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_data` out 32: extended result.
- `rsp_err` out 1: reserved size, misaligned access (when the macro is enabled), or timeout.
- `busy` out 1: state is not IDLE.

## Operation
- The state machine has three states: IDLE, WAIT and RESP.
- **IDLE:**
  - `req_ready` is 1.
  - When `req_valid` is high, latch `req_addr[1:0]`, `req_size` and `req_sign`, and set `mem_addr` to `{req_addr[ADDR_WIDTH-1:2], 2'b00}`.
  - If the request is an error case, go to RESP with `rsp_err` = 1 and `rsp_data` = 0. No memory access is made.
  - Otherwise go to WAIT and clear the timeout counter.
- **WAIT:**
  - `mem_rd` is 1.
  - The timeout counter is $clog2(MEM_TIMEOUT+1) bits wide and increments every WAIT cycle without an acknowledge.
  - On `mem_ack`, register the extended lane into `rsp_data`, clear `rsp_err` and go to RESP.
  - If the counter reaches MEM_TIMEOUT without an acknowledge, set `rsp_err` = 1 and `rsp_data` = 0, deassert `mem_rd` and go to RESP.
  - If `mem_ack` arrives in the same cycle the counter reaches MEM_TIMEOUT, the acknowledge wins.
- **RESP:**
  - `rsp_valid` is 1. `rsp_data` and `rsp_err` are held stable.
  - When `rsp_ready` is high, go to IDLE.
- **Lane selection** (little-endian):
  - Byte: `mem_rdata[8n+7:8n]` with n = `addr[1:0]`.
  - Half: `mem_rdata[16h+15:16h]` with h = `addr[1]`.
  - Word: `mem_rdata` is returned unchanged.
- **Extension:** the sign bit is the lane MSB when `req_sign` = 1, and 0 otherwise.
- **Ignored inputs:** `mem_ack` in IDLE or RESP is ignored. A request is never accepted outside IDLE.
- **Reset:** `rst_n` low at a clock edge forces IDLE from any state, including mid-WAIT. The outstanding read is abandoned, and the memory side must tolerate the dropped strobe.

## Timing
- **Reset values:**
  - `mem_rd`, `rsp_valid`, `rsp_err` and `busy` are 0.
  - `rsp_data` and `mem_addr` are 0.
  - `req_ready` is 1 from the first clock edge with `rst_n` low.
- **Latency:**
  - A request accepted at edge 0 gives `mem_rd` = 1 in cycle 1.
  - An acknowledge in cycle k gives `rsp_valid` = 1 in cycle k+1.
  - Minimum request-to-response latency is 2 cycles.
  - An error request gives `rsp_valid` in cycle 1.
- **Throughput:** after the response handshake, `req_ready` returns the next cycle. This is one bubble, so the maximum rate is one load per 3 cycles.
- **Output registering:** all outputs are registered or decoded directly from the state. There is no combinational path from `mem_rdata` to `rsp_data`.

## Configuration
- **`LOAD_MISALIGN_TRAP_EN` defined:** a half load with `addr[0]` = 1, or a word load with `addr[1:0]` ≠ 0, is an error. It goes straight to RESP with `rsp_err` = 1 and `rsp_data` = 0, and `mem_rd` is never asserted.
- **`LOAD_MISALIGN_TRAP_EN` undefined:** the low address bits are silently ignored. A half load uses h = `addr[1]`, and a word load returns the whole word. Only reserved sizes and timeouts raise `rsp_err`.

## Structure
- **Package `load_pkg`:**
  - Size encodings `LS_BYTE`, `LS_HALF`, `LS_WORD`, `LS_RSVD`.
  - Enum `load_state_t` with `ST_IDLE`, `ST_WAIT`, `ST_RESP`.
- **Sub-module `load_lane_ext`:** purely combinational. Inputs are the data word, `addr[1:0]`, size and sign; output is the extended 32-bit value. The parent registers its output on `mem_ack`.

## Test plan
All scenarios use `mem_rdata` = 0x8077_F0A5 unless stated.
- **Byte loads:** LB at 0x100 with sign = 1 → `rsp_data` = 0xFFFF_FFA5. LBU at 0x103 → 0x0000_0080. `mem_addr` = 0x100 in both cases.
- **Half loads:** LH at 0x102 with sign = 1 → 0xFFFF_8077. LHU at 0x100 → 0x0000_F0A5. Acknowledge delayed 5 cycles → `mem_rd` held 5 cycles and `rsp_valid` appears on the following cycle.
- **Word load with response back-pressure:** LW at 0x104 → `mem_addr` = 0x104 and `rsp_data` = 0x8077_F0A5. Hold `rsp_ready` low for 3 cycles → `rsp_valid` and `rsp_data` stay stable and `req_ready` stays 0.
- **Timeout:** with MEM_TIMEOUT = 4 and no acknowledge → `rsp_err` = 1 and `rsp_data` = 0 after 4 WAIT cycles. An acknowledge in the 4th WAIT cycle → normal data and `rsp_err` = 0.
- **Misaligned and reserved requests:** LH at 0x101 with the macro defined → `rsp_err` = 1 in cycle 1 and `mem_rd` never asserted. Without the macro → `rsp_data` = 0xFFFF_F0A5. `req_size` = 11 → `rsp_err` = 1 in both builds.
- **Reset mid-WAIT:** drive `rst_n` low mid-WAIT → next cycle IDLE, `mem_rd` = 0 and `rsp_valid` = 0. A late `mem_ack` is ignored, and a new LB completes normally.

Source files
------------

// File: rtl/load_pkg.sv
// Shared encodings for the load extension controller: size codes and FSM states.
package load_pkg;

    localparam logic [1:0] LS_BYTE = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_WORD = 2'b10;
    localparam logic [1:0] LS_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } load_state_t;

endpackage

// File: rtl/load_lane_ext.sv
// Little-endian byte/halfword lane select with sign or zero extension (combinational).
module load_lane_ext
    import load_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        sign,
    output logic [31:0] ext
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = data[7:0];
        case (addr)
            2'd0:    byte_lane = data[7:0];
            2'd1:    byte_lane = data[15:8];
            2'd2:    byte_lane = data[23:16];
            default: byte_lane = data[31:24];
        endcase
        half_lane = addr[1] ? data[31:16] : data[15:0];

        ext = '0;
        case (size)
            LS_BYTE: ext = {{24{sign & byte_lane[7]}}, byte_lane};
            LS_HALF: ext = {{16{sign & half_lane[15]}}, half_lane};
            LS_WORD: ext = data;
            default: ext = '0;
        endcase
    end

endmodule

// File: rtl/load_ext_ctrl.sv
// Multi-cycle load controller: one word read, lane extension, valid/ready response.
// Define LOAD_MISALIGN_TRAP_EN to turn misaligned half/word loads into error responses.
module load_ext_ctrl
    import load_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_sign,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_data,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam bit          TIMEOUT_EN = (MEM_TIMEOUT != 0);
    localparam int unsigned CNT_W      = TIMEOUT_EN ? $clog2(MEM_TIMEOUT + 1) : 1;
    // Compare against TIMEOUT-1: the cycle that would bump the counter to TIMEOUT is the last.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    load_state_t           state_q, state_d;
    logic [1:0]            addr_lo_q, addr_lo_d;
    logic [1:0]            size_q, size_d;
    logic                  sign_q, sign_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [31:0]           lane_ext;
    logic                  req_err;

    load_lane_ext u_lane_ext (
        .data (mem_rdata),
        .addr (addr_lo_q),
        .size (size_q),
        .sign (sign_q),
        .ext  (lane_ext)
    );

    always_comb begin
        req_err = (req_size == LS_RSVD);
`ifdef LOAD_MISALIGN_TRAP_EN
        if ((req_size == LS_HALF) && req_addr[0]) req_err = 1'b1;
        if ((req_size == LS_WORD) && (req_addr[1:0] != 2'b00)) req_err = 1'b1;
`endif
    end

    always_comb begin
        state_d    = state_q;
        addr_lo_d  = addr_lo_q;
        size_d     = size_q;
        sign_d     = sign_q;
        mem_addr_d = mem_addr_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        cnt_d      = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_lo_d  = req_addr[1:0];
                    size_d     = req_size;
                    sign_d     = req_sign;
                    mem_addr_d = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                    if (req_err) begin
                        state_d    = ST_RESP;
                        rsp_err_d  = 1'b1;
                        rsp_data_d = '0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            ST_WAIT: begin
                if (mem_ack) begin
                    state_d    = ST_RESP;
                    rsp_data_d = lane_ext;
                    rsp_err_d  = 1'b0;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    state_d    = ST_RESP;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_lo_q  <= '0;
            size_q     <= LS_BYTE;
            sign_q     <= 1'b0;
            mem_addr_q <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_lo_q  <= addr_lo_d;
            size_q     <= size_d;
            sign_q     <= sign_d;
            mem_addr_q <= mem_addr_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign mem_rd    = (state_q == ST_WAIT);
    assign rsp_valid = (state_q == ST_RESP);
    assign mem_addr  = mem_addr_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_load_ext_ctrl.sv
// Bench for load_ext_ctrl: directed scenarios plus random loads against a behavioural model.
// Expectations follow LOAD_MISALIGN_TRAP_EN when it is defined for the build.
module tb_load_ext_ctrl;

    localparam logic [31:0] RDATA = 32'h8077_F0A5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic        req_sign = 1'b0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        rsp_ready = 1'b0;
    logic        sel = 1'b0;  // 0: default-timeout DUT, 1: MEM_TIMEOUT=4 DUT

    logic        req_ready_a, mem_rd_a, rsp_valid_a, rsp_err_a, busy_a;
    logic [31:0] mem_addr_a, rsp_data_a;
    logic        req_ready_b, mem_rd_b, rsp_valid_b, rsp_err_b, busy_b;
    logic [31:0] mem_addr_b, rsp_data_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    load_ext_ctrl u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid & ~sel),
        .req_ready (req_ready_a),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_sign  (req_sign),
        .mem_rd    (mem_rd_a),
        .mem_addr  (mem_addr_a),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .rsp_valid (rsp_valid_a),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data_a),
        .rsp_err   (rsp_err_a),
        .busy      (busy_a)
    );

    load_ext_ctrl #(.ADDR_WIDTH(32), .MEM_TIMEOUT(4)) u_dut_to (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid & sel),
        .req_ready (req_ready_b),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_sign  (req_sign),
        .mem_rd    (mem_rd_b),
        .mem_addr  (mem_addr_b),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .rsp_valid (rsp_valid_b),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data_b),
        .rsp_err   (rsp_err_b),
        .busy      (busy_b)
    );

    wire        o_req_ready = sel ? req_ready_b : req_ready_a;
    wire        o_mem_rd    = sel ? mem_rd_b    : mem_rd_a;
    wire        o_rsp_valid = sel ? rsp_valid_b : rsp_valid_a;
    wire        o_rsp_err   = sel ? rsp_err_b   : rsp_err_a;
    wire        o_busy      = sel ? busy_b      : busy_a;
    wire [31:0] o_mem_addr  = sel ? mem_addr_b  : mem_addr_a;
    wire [31:0] o_rsp_data  = sel ? rsp_data_b  : rsp_data_a;

    // Behavioural expectation for one load; ack_at = WAIT cycle carrying mem_ack, 0 = never.
    function automatic void model(input logic [31:0] addr, input logic [1:0] size,
                                  input logic sign, input logic [31:0] rdata, input int ack_at,
                                  input int tmo, output logic [31:0] data, output logic err,
                                  output int rd, output int lat);
        longint v;
        bit     misalign;
        misalign = 1'b0;
`ifdef LOAD_MISALIGN_TRAP_EN
        misalign = (size == 2'd1 && (addr % 2) != 0) || (size == 2'd2 && (addr % 4) != 0);
`endif
        v = 0;
        if (size == 2'd3 || misalign) begin
            data = '0; err = 1'b1; rd = 0; lat = 1;
        end else if (ack_at < 1 || ack_at > tmo) begin
            data = '0; err = 1'b1; rd = tmo; lat = tmo + 1;
        end else begin
            err = 1'b0; rd = ack_at; lat = ack_at + 1;
            if (size == 2'd0) begin
                v = longint'((rdata >> (8 * (addr % 4))) % 256);
                if (sign && v >= 128) v = v - 256;
            end else if (size == 2'd1) begin
                v = longint'((rdata >> (16 * ((addr / 2) % 2))) % 65536);
                if (sign && v >= 32768) v = v - 65536;
            end else begin
                v = longint'(rdata);
            end
            data = v[31:0];
        end
    endfunction

    // Drives one request and records what the selected DUT does; no judgement here.
    task automatic drive_load(input logic [31:0] addr, input logic [1:0] size, input logic sign,
                              input logic [31:0] rdata, input int ack_at, input int stall,
                              output logic [31:0] data, output logic err, output int rd_cycles,
                              output int lat, output logic [31:0] maddr,
                              output logic stable_ok, output logic ready_after);
        int waits;
        rd_cycles = 0; lat = -1; stable_ok = 1'b1; ready_after = 1'b0;
        data = '0; err = 1'b0; waits = 0;
        req_addr = addr; req_size = size; req_sign = sign; mem_rdata = rdata;
        rsp_ready = 1'b0; mem_ack = 1'b0; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        maddr = o_mem_addr;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            mem_ack = 1'b0;
            if (o_rsp_valid === 1'b1) begin
                lat = cyc;
                break;
            end
            if (o_mem_rd === 1'b1) begin
                rd_cycles++;
                waits++;
                if (waits == ack_at) mem_ack = 1'b1;
            end
            @(negedge clk);
        end
        if (lat < 0) return;
        data = o_rsp_data;
        err  = o_rsp_err;
        repeat (stall) begin
            @(negedge clk);
            if (!(o_rsp_valid === 1'b1 && o_rsp_data === data && o_rsp_err === err &&
                  o_req_ready === 1'b0)) stable_ok = 1'b0;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        ready_after = (o_req_ready === 1'b1);
    endtask

    task automatic test_reset();
        sel = 1'b0; rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++; if (o_req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", o_req_ready); end
        n_tests++; if (o_mem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rd: got %b want 0", o_mem_rd); end
        n_tests++; if (o_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", o_rsp_valid); end
        n_tests++; if (o_rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b want 0", o_rsp_err); end
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        n_tests++; if (o_rsp_data !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_data: got %h want 0", o_rsp_data); end
        n_tests++; if (o_mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", o_mem_addr); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_byte();
        logic [31:0] d, ma; logic e, st, ra; int rd, lat;
        sel = 1'b0;
        drive_load(32'h100, 2'b00, 1'b1, RDATA, 1, 0, d, e, rd, lat, ma, st, ra);
        n_tests++; if (d !== 32'hFFFF_FFA5 || e !== 1'b0) begin n_fail++; $display("FAIL lb_data: got %h err %b want ffffffa5 err 0", d, e); end
        n_tests++; if (ma !== 32'h100) begin n_fail++; $display("FAIL lb_mem_addr: got %h want 00000100", ma); end
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL lb_latency: got %0d want 2", lat); end
        drive_load(32'h103, 2'b00, 1'b0, RDATA, 1, 0, d, e, rd, lat, ma, st, ra);
        n_tests++; if (d !== 32'h0000_0080 || e !== 1'b0) begin n_fail++; $display("FAIL lbu_data: got %h err %b want 00000080 err 0", d, e); end
        n_tests++; if (ma !== 32'h100) begin n_fail++; $display("FAIL lbu_mem_addr: got %h want 00000100", ma); end
    endtask

    task automatic test_half();
        logic [31:0] d, ma; logic e, st, ra; int rd, lat;
        sel = 1'b0;
        drive_load(32'h102, 2'b01, 1'b1, RDATA, 1, 0, d, e, rd, lat, ma, st, ra);
        n_tests++; if (d !== 32'hFFFF_8077) begin n_fail++; $display("FAIL lh_data: got %h want ffff8077", d); end
        drive_load(32'h100, 2'b01, 1'b0, RDATA, 5, 0, d, e, rd, lat, ma, st, ra);
        n_tests++; if (d !== 32'h0000_F0A5) begin n_fail++; $display("FAIL lhu_data: got %h want 0000f0a5", d); end
        n_tests++; if (rd !== 5) begin n_fail++; $display("FAIL lhu_rd_cycles: got %0d want 5", rd); end
        n_tests++; if (lat !== 6) begin n_fail++; $display("FAIL lhu_latency: got %0d want 6", lat); end
    endtask

    task automatic test_word_backpressure();
        logic [31:0] d, ma; logic e, st, ra; int rd, lat;
        sel = 1'b0;
        drive_load(32'h104, 2'b10, 1'b1, RDATA, 2, 3, d, e, rd, lat, ma, st, ra);
        n_tests++; if (ma !== 32'h104) begin n_fail++; $display("FAIL lw_mem_addr: got %h want 00000104", ma); end
        n_tests++; if (d !== RDATA || e !== 1'b0) begin n_fail++; $display("FAIL lw_data: got %h err %b want %h err 0", d, e, RDATA); end
        n_tests++; if (st !== 1'b1) begin n_fail++; $display("FAIL lw_stall_stable: got %b want 1", st); end
        n_tests++; if (ra !== 1'b1) begin n_fail++; $display("FAIL lw_ready_after: got %b want 1", ra); end
    endtask

    task automatic test_timeout();
        logic [31:0] d, ma; logic e, st, ra; int rd, lat;
        sel = 1'b1;
        drive_load(32'h108, 2'b10, 1'b0, RDATA, 0, 0, d, e, rd, lat, ma, st, ra);
        n_tests++; if (e !== 1'b1 || d !== 32'h0) begin n_fail++; $display("FAIL timeout_err: got %h err %b want 0 err 1", d, e); end
        n_tests++; if (rd !== 4 || lat !== 5) begin n_fail++; $display("FAIL timeout_cycles: got rd %0d lat %0d want rd 4 lat 5", rd, lat); end
        drive_load(32'h108, 2'b10, 1'b0, RDATA, 4, 0, d, e, rd, lat, ma, st, ra);
        n_tests++; if (e !== 1'b0 || d !== RDATA) begin n_fail++; $display("FAIL ack_at_limit: got %h err %b want %h err 0", d, e, RDATA); end
        sel = 1'b0;
    endtask

    task automatic test_misaligned();
        logic [31:0] d, ma; logic e, st, ra; int rd, lat;
        sel = 1'b0;
        drive_load(32'h101, 2'b01, 1'b1, RDATA, 1, 0, d, e, rd, lat, ma, st, ra);
`ifdef LOAD_MISALIGN_TRAP_EN
        n_tests++; if (e !== 1'b1 || d !== 32'h0 || rd !== 0 || lat !== 1) begin n_fail++; $display("FAIL lh_misalign: got %h err %b rd %0d lat %0d want 0 err 1 rd 0 lat 1", d, e, rd, lat); end
`else
        n_tests++; if (e !== 1'b0 || d !== 32'hFFFF_F0A5) begin n_fail++; $display("FAIL lh_misalign: got %h err %b want fffff0a5 err 0", d, e); end
`endif
        drive_load(32'h100, 2'b11, 1'b0, RDATA, 1, 0, d, e, rd, lat, ma, st, ra);
        n_tests++; if (e !== 1'b1 || d !== 32'h0 || rd !== 0 || lat !== 1) begin n_fail++; $display("FAIL reserved_size: got %h err %b rd %0d lat %0d want 0 err 1 rd 0 lat 1", d, e, rd, lat); end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] d, ma; logic e, st, ra; int rd, lat;
        sel = 1'b0;
        req_addr = 32'h200; req_size = 2'b10; req_sign = 1'b0; mem_ack = 1'b0; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++; if (o_mem_rd !== 1'b0 || o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1 || o_busy !== 1'b0) begin n_fail++; $display("FAIL midwait_reset: got rd %b vld %b rdy %b busy %b want 0 0 1 0", o_mem_rd, o_rsp_valid, o_req_ready, o_busy); end
        rst_n = 1'b1; mem_rdata = RDATA; mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        n_tests++; if (o_rsp_valid !== 1'b0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL late_ack_ignored: got vld %b busy %b want 0 0", o_rsp_valid, o_busy); end
        drive_load(32'h100, 2'b00, 1'b1, RDATA, 1, 0, d, e, rd, lat, ma, st, ra);
        n_tests++; if (d !== 32'hFFFF_FFA5 || e !== 1'b0) begin n_fail++; $display("FAIL post_reset_lb: got %h err %b want ffffffa5 err 0", d, e); end
    endtask

    task automatic test_random();
        logic [31:0] d, ma, a, rdat, xd; logic e, st, ra, xe, sg; logic [1:0] sz;
        int rd, lat, xrd, xlat, ack, stall, tmo;
        for (int i = 0; i < 40; i++) begin
            sel   = ($urandom_range(0, 3) == 0);
            tmo   = sel ? 4 : 255;
            ack   = sel ? int'($urandom_range(0, 5)) : int'($urandom_range(1, 6));
            stall = int'($urandom_range(0, 2));
            a     = $urandom; sz = 2'($urandom_range(0, 3)); sg = 1'($urandom);
            rdat  = $urandom;
            model(a, sz, sg, rdat, ack, tmo, xd, xe, xrd, xlat);
            drive_load(a, sz, sg, rdat, ack, stall, d, e, rd, lat, ma, st, ra);
            n_tests++; if (d !== xd || e !== xe) begin n_fail++; $display("FAIL rand_rsp[%0d]: got %h err %b want %h err %b", i, d, e, xd, xe); end
            n_tests++; if (rd !== xrd || lat !== xlat) begin n_fail++; $display("FAIL rand_timing[%0d]: got rd %0d lat %0d want rd %0d lat %0d", i, rd, lat, xrd, xlat); end
            n_tests++; if (ma !== a - (a % 4)) begin n_fail++; $display("FAIL rand_mem_addr[%0d]: got %h want %h", i, ma, a - (a % 4)); end
            n_tests++; if (st !== 1'b1 || ra !== 1'b1) begin n_fail++; $display("FAIL rand_handshake[%0d]: got stable %b ready %b want 1 1", i, st, ra); end
        end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_byte();
        test_half();
        test_word_backpressure();
        test_timeout();
        test_misaligned();
        test_reset_mid_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
